cond_unit: RTL

Parametrised condition unit for the CPU control path. It holds `NUM_FLAGSETS` architectural NZCV flag registers and evaluates the 4-bit condition field of each instruction against a selected set. Flag writes are gated by the instruction's own condition result. A predication counter applies one stored condition to the next `PRED_DEPTH` or fewer instructions. It sits between decode and writeback control and replaces the purely combinational condition check.

---
 rtl/cond_pkg.sv | 12 +
 rtl/cond_eval.sv | 30 +++
 rtl/cond_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, NZCV bit positions and flag write-enable bit positions
package cond_pkg;
    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FWE_NZ = 1;
    localparam int FWE_CV = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational decode of a 4-bit condition against NZCV flags
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       ex,
    output logic       undef
);
    logic n, z, c, v, base;
    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = n == v;
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        // odd codes invert their even partner, except the AL/NV pair
        undef = cond == NV;
        ex    = undef ? 1'b0 : base ^ (cond[0] & (cond[3:1] != 3'd7));
    end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag sets, gated flag writes, condition evaluation and predication counter
module cond_unit
    import cond_pkg::*;
#(
    parameter  int NUM_FLAGSETS = 2,
    parameter  int PRED_DEPTH   = 4,
    localparam int SW = (NUM_FLAGSETS > 1) ? $clog2(NUM_FLAGSETS) : 1,
    localparam int LW = $clog2(PRED_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    cond,
    input  logic [SW-1:0] sel_set,
    input  logic [3:0]    alu_flags,
    input  logic [1:0]    flag_we,
    input  logic          pred_start,
    input  logic [LW-1:0] pred_len,
    input  logic [3:0]    pred_cond,
    output logic          cond_ex,
    output logic          cond_undef,
    output logic [3:0]    flags_out,
    output logic          pred_active,
    output logic          cond_ex_q
);
    localparam logic [SW:0]   NSETS   = (SW + 1)'(NUM_FLAGSETS);
    localparam logic [LW-1:0] MAX_LEN = LW'(PRED_DEPTH);

    logic [3:0]    flags_q [NUM_FLAGSETS];
    logic [3:0]    flags_d [NUM_FLAGSETS];
    logic [LW-1:0] cnt_q, cnt_d;
    logic [3:0]    pred_cond_q, pred_cond_d;
    logic          cond_ex_d;
    logic          sel_ok, start_ok;
    logic [3:0]    eff;

    assign sel_ok      = {1'b0, sel_set} < NSETS;
    assign flags_out   = sel_ok ? flags_q[sel_set] : 4'b0000;
    assign pred_active = cnt_q != '0;
    assign eff         = pred_active ? pred_cond_q : cond;
    assign start_ok    = pred_start & (pred_len != '0) & (pred_len <= MAX_LEN);

    cond_eval u_eval (
        .cond  (eff),
        .flags (flags_out),
        .ex    (cond_ex),
        .undef (cond_undef)
    );

    always_comb begin
        flags_d = flags_q;
        if (en && cond_ex && sel_ok) begin
            if (flag_we[FWE_NZ]) begin
                flags_d[sel_set][FLAG_N] = alu_flags[FLAG_N];
                flags_d[sel_set][FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flag_we[FWE_CV]) begin
                flags_d[sel_set][FLAG_C] = alu_flags[FLAG_C];
                flags_d[sel_set][FLAG_V] = alu_flags[FLAG_V];
            end
        end
        cnt_d       = !en ? cnt_q : start_ok ? pred_len : pred_active ? cnt_q - 1'b1 : cnt_q;
        pred_cond_d = (en && start_ok) ? pred_cond : pred_cond_q;
        cond_ex_d   = en ? cond_ex : cond_ex_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '{default: '0};
            cnt_q       <= '0;
            pred_cond_q <= AL;
            cond_ex_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            pred_cond_q <= pred_cond_d;
            cond_ex_q   <= cond_ex_d;
        end
    end
endmodule
